// File: rtl/rs_rx_frontend.sv
// rtl/rs_rx_frontend.sv - RS(15,9) receive front end: symbol assembly, Horner syndromes, decode strobe
// Collects 15 serial GF(16) symbols, holds the word and S1..S6 for the decoder.
module rs_rx_frontend #(
    parameter int N_SYM = 15,
    parameter int N_SYN = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [3:0]           in_sym,
    output logic                 in_ready,
    input  logic                 decoderBusy,
    output logic                 decodeMessage,
    output logic [4*N_SYM-1:0]   recievedWordIn,
    output logic [4*N_SYN-1:0]   syndromes,
    output logic                 word_clean,
    output logic                 frame_err
);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t               state_q, state_d;
    logic [3:0]           sym_cnt_q, sym_cnt_d;
    logic [4*N_SYM-1:0]   shift_q, shift_d;
    logic [4*N_SYN-1:0]   acc_q, acc_d;
    logic [4*N_SYM-1:0]   word_q, word_d;
    logic [4*N_SYN-1:0]   syn_q, syn_d;
    logic                 clean_q, clean_d;
    logic                 load_q, load_d;
    logic                 ready_q, ready_d;
    logic                 strobe_q, strobe_d;
    logic                 ferr_q, ferr_d;
    logic                 accept, last;
    logic [3:0]           cnt_eff, pos;

    // Multiply by alpha^j as j chained xtime steps; j is constant at each use.
    function automatic logic [3:0] mul_alpha(input logic [3:0] a, input int j);
        logic [3:0] r;
        r = a;
        for (int k = 0; k < j; k++) r = {r[2:0], 1'b0} ^ {2'b00, r[3], r[3]};
        return r;
    endfunction

    assign accept  = in_valid && ready_q;
    assign cnt_eff = in_sof ? 4'd0 : sym_cnt_q;
    assign last    = accept && (cnt_eff == 4'(N_SYM - 1));
    assign pos     = 4'(N_SYM - 1) - cnt_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= COLLECT;
        else        state_q <= state_d;
    end

    // load_q marks the first HOLD cycle, when the outputs are refreshed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (last) state_d = HOLD;
            HOLD:    if (!decoderBusy && !load_q) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        strobe_d = (state_q == HOLD) && !decoderBusy && !load_q;
        ready_d  = (state_d == COLLECT);
        ferr_d   = accept && in_sof && (sym_cnt_q != 4'd0);
        load_d   = last;
    end

    always_comb begin
        sym_cnt_d = sym_cnt_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        word_d    = word_q;
        syn_d     = syn_q;
        clean_d   = clean_q;
        if (accept) begin
            sym_cnt_d = last ? 4'd0 : cnt_eff + 4'd1;
            shift_d[{pos, 2'b00} +: 4] = in_sym;
            for (int j = 0; j < N_SYN; j++)
                acc_d[4*j +: 4] = ((cnt_eff == 4'd0) ? 4'd0 : mul_alpha(acc_q[4*j +: 4], j + 1)) ^ in_sym;
        end
        if (load_q) begin
            word_d  = shift_q;
            syn_d   = acc_q;
            clean_d = (acc_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt_q <= '0;
            shift_q   <= '0;
            acc_q     <= '0;
            word_q    <= '0;
            syn_q     <= '0;
            clean_q   <= 1'b0;
            load_q    <= 1'b0;
            ready_q   <= 1'b0;
            strobe_q  <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            word_q    <= word_d;
            syn_q     <= syn_d;
            clean_q   <= clean_d;
            load_q    <= load_d;
            ready_q   <= ready_d;
            strobe_q  <= strobe_d;
            ferr_q    <= ferr_d;
        end
    end

    assign in_ready       = ready_q;
    assign decodeMessage  = strobe_q;
    assign recievedWordIn = word_q;
    assign syndromes      = syn_q;
    assign word_clean     = clean_q;
    assign frame_err      = ferr_q;

endmodule

// File: tb/tb_rs_rx_frontend.sv
// tb/tb_rs_rx_frontend.sv - self-checking bench for rs_rx_frontend against a polynomial-evaluation model
module tb_rs_rx_frontend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sof;
    logic [3:0]  in_sym;
    logic        in_ready;
    logic        decoderBusy;
    logic        decodeMessage;
    logic [59:0] recievedWordIn;
    logic [23:0] syndromes;
    logic        word_clean;
    logic        frame_err;

    rs_rx_frontend dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_sof         (in_sof),
        .in_sym         (in_sym),
        .in_ready       (in_ready),
        .decoderBusy    (decoderBusy),
        .decodeMessage  (decodeMessage),
        .recievedWordIn (recievedWordIn),
        .syndromes      (syndromes),
        .word_clean     (word_clean),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int strobe_seen = 0;
    int strobe_exp = 0;

    logic [3:0]  fr [15];
    logic [59:0] hold_word;
    logic [23:0] hold_syn;
    logic        hold_clean;

    always @(negedge clk) if (decodeMessage === 1'b1) strobe_seen++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 4; i++) if (b[i]) p = p ^ ({4'h0, a} << i);
        for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
        return p[3:0];
    endfunction

    function automatic logic [3:0] apow(input int e);
        logic [3:0] r;
        r = 4'h1;
        for (int k = 0; k < (e % 15); k++) r = gmul(r, 4'h2);
        return r;
    endfunction

    task automatic send_sym(input logic [3:0] sym, input logic sof, input logic err_exp);
        int n;
        in_valid = 1'b1;
        in_sof   = sof;
        in_sym   = sym;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("frame_err", 64'(frame_err), 64'(err_exp));
        chk("held_word", 64'(recievedWordIn), 64'(hold_word));
        chk("held_syn", 64'(syndromes), 64'(hold_syn));
        chk("collect_no_strobe", 64'(decodeMessage), 64'd0);
    endtask

    // p partial symbols precede the real frame (restarted with in_sof when p>0).
    task automatic run_frame(input int p, input int busy_cyc);
        logic [59:0] ew;
        logic [23:0] es;
        logic [3:0]  s;
        decoderBusy = (busy_cyc > 0);
        for (int i = 0; i < p; i++)
            send_sym(4'($urandom), (i == 0) ? 1'($urandom) : 1'b0, 1'b0);
        for (int i = 0; i < 15; i++)
            send_sym(fr[i], (i == 0) ? ((p > 0) ? 1'b1 : 1'($urandom)) : 1'b0, (i == 0) && (p > 0));
        ew = '0;
        for (int i = 0; i < 15; i++) ew[4*i +: 4] = fr[14-i];
        for (int j = 1; j <= 6; j++) begin
            s = 4'h0;
            for (int i = 0; i < 15; i++) s = s ^ gmul(fr[14-i], apow(i * j));
            es[4*(j-1) +: 4] = s;
        end
        @(posedge clk); #1;
        chk("word", 64'(recievedWordIn), 64'(ew));
        chk("syn", 64'(syndromes), 64'(es));
        chk("clean", 64'(word_clean), 64'(es == 24'h0));
        chk("hold_ready", 64'(in_ready), 64'd0);
        chk("early_strobe", 64'(decodeMessage), 64'd0);
        hold_word  = ew;
        hold_syn   = es;
        hold_clean = (es == 24'h0);
        for (int c = 0; c < busy_cyc; c++) begin
            @(posedge clk); #1;
            chk("busy_ready", 64'(in_ready), 64'd0);
            chk("busy_strobe", 64'(decodeMessage), 64'd0);
        end
        decoderBusy = 1'b0;
        @(posedge clk); #1;
        chk("strobe", 64'(decodeMessage), 64'd1);
        chk("strobe_ready", 64'(in_ready), 64'd1);
        strobe_exp++;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_sym = 4'h0; decoderBusy = 1'b0;
        hold_word = '0; hold_syn = '0; hold_clean = 1'b0;
        #3;
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_word", 64'(recievedWordIn), 64'd0);
        chk("rst_syn", 64'(syndromes), 64'd0);
        chk("rst_strobe", 64'(decodeMessage), 64'd0);
        chk("rst_clean", 64'(word_clean), 64'd0);
        chk("rst_ferr", 64'(frame_err), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 15; i++) fr[i] = 4'h0;
        run_frame(0, 0);
        chk("tp_zero_clean", 64'(word_clean), 64'd1);

        fr[14] = 4'h1;
        run_frame(0, 0);
        chk("tp_pos0_syn", 64'(syndromes), 64'h111111);
        chk("tp_pos0_word", 64'(recievedWordIn), 64'h1);
        chk("tp_pos0_clean", 64'(word_clean), 64'd0);

        fr[14] = 4'h0; fr[13] = 4'h1;
        run_frame(0, 0);
        chk("tp_pos1_syn", 64'(syndromes), 64'hC63842);
        chk("tp_pos1_word", 64'(recievedWordIn), 64'h10);

        for (int i = 0; i < 15; i++) fr[i] = 4'($urandom);
        run_frame(0, 20);
        for (int i = 0; i < 15; i++) fr[i] = 4'($urandom);
        run_frame(7, 0);

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 15; i++) fr[i] = 4'($urandom);
            if (f % 4 == 0) fr[$urandom_range(14, 0)] = 4'h0;
            run_frame(($urandom_range(1, 0) == 1) ? int'($urandom_range(13, 1)) : 0,
                      int'($urandom_range(3, 0)));
        end

        for (int i = 0; i < 15; i++) fr[i] = 4'($urandom);
        decoderBusy = 1'b1;
        for (int i = 0; i < 15; i++) send_sym(fr[i], i == 0, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("hold_rst_word", 64'(recievedWordIn), 64'd0);
        chk("hold_rst_syn", 64'(syndromes), 64'd0);
        chk("hold_rst_clean", 64'(word_clean), 64'd0);
        chk("hold_rst_ready", 64'(in_ready), 64'd0);
        decoderBusy = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        hold_word = '0; hold_syn = '0; hold_clean = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_strobe", 64'(strobe_seen), 64'(strobe_exp));

        for (int i = 0; i < 15; i++) fr[i] = 4'($urandom);
        run_frame(0, 1);
        @(posedge clk); #1;
        chk("final_strobe_count", 64'(strobe_seen), 64'(strobe_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
